// File: rtl/tt_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_trace_capture
// Purpose  : On-chip logic analyser. Samples a probe bus into a circular
//            buffer, stops POST samples after a masked-compare trigger, then
//            replays the captured window oldest-first, one sample per rd_en.
// Revision : 1.0 - initial release
// ============================================================================
module tt_trace_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int POST  = DEPTH / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena_i,
  input  logic [WIDTH-1:0]         probe_i,
  input  logic [WIDTH-1:0]         trig_mask_i,
  input  logic [WIDTH-1:0]         trig_value_i,
  input  logic                     arm_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_POST  = (AW+1)'(POST);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      post_q, post_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w_match;
  logic             w_we;
  logic [AW-1:0]    w_wptr_inc;
  logic [AW:0]      w_count_inc;
  logic [AW:0]      w_post_inc;
  logic [AW-1:0]    w_rptr_load;

  // Sample-path helpers shared by the PRE and POST states
  always_comb begin
    w_match     = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
    w_we        = ena_i && !arm_i && ((state_q == S_PRE) || (state_q == S_POST));
    w_wptr_inc  = wptr_q + AW'(1);
    w_count_inc = (count_q == C_DEPTH) ? count_q : count_q + (AW+1)'(1);
    w_post_inc  = post_q + (AW+1)'(1);
    // Oldest surviving sample once the current write lands; a full buffer
    // has zero low bits in count, so this lands on the write pointer itself.
    w_rptr_load = w_wptr_inc - w_count_inc[AW-1:0];
  end

  // Capture/readout state machine next-state logic; arm overrides everything
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (arm_i) begin
      state_d = S_PRE;
      wptr_d  = '0;
      count_d = '0;
      post_d  = '0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (ena_i) begin
            wptr_d  = w_wptr_inc;
            count_d = w_count_inc;
            if (w_match) begin
              post_d = (AW+1)'(1);
              if (C_POST == (AW+1)'(1)) begin
                state_d = S_DONE;
                rptr_d  = w_rptr_load;
              end else begin
                state_d = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (ena_i) begin
            wptr_d  = w_wptr_inc;
            count_d = w_count_inc;
            post_d  = w_post_inc;
            if (w_post_inc == C_POST) begin
              state_d = S_DONE;
              rptr_d  = w_rptr_load;
            end
          end
        end
        S_DONE: begin
          if (rd_en_i) begin
            rd_data_d  = mem_q[rptr_q];
            rd_valid_d = 1'b1;
            rptr_d     = rptr_q + AW'(1);
            count_d    = count_q - (AW+1)'(1);
            if (count_q == (AW+1)'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sample buffer; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[wptr_q] <= probe_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign state_o    = state_q;
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_trace_capture
// Purpose  : Directed self-checking bench for tt_trace_capture
//            (WIDTH=8, DEPTH=8, POST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_trace_capture;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] probe;
  logic [7:0] trig_mask;
  logic [7:0] trig_value;
  logic       arm;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [1:0] state;
  logic [3:0] count;

  int n_checks;
  int n_fail;

  tt_trace_capture #(
    .WIDTH (8),
    .DEPTH (8),
    .POST  (4)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena_i        (ena),
    .probe_i      (probe),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .arm_i        (arm),
    .rd_en_i      (rd_en),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .state_o      (state),
    .count_o      (count)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [7:0] m, input logic [7:0] v);
    trig_mask  = m;
    trig_value = v;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state", state, 1);
    check("arm_count", count, 0);
  endtask

  // Feed an incrementing probe with ena high until DONE (bounded)
  task automatic run_to_done(input logic [7:0] start, input logic [3:0] exp_count);
    logic [7:0] p;
    int n;
    p = start;
    n = 0;
    ena = 1'b1;
    while (state != 2'd3 && n < 40) begin
      probe = p;
      tick();
      p = p + 8'd1;
      n++;
    end
    check("done_state", state, 3);
    check("done_count", count, exp_count);
  endtask

  // Back-to-back reads of an incrementing sequence
  task automatic read_seq(input logic [7:0] first, input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, first + 8'(i));
    end
    rd_en = 1'b0;
  endtask

  task automatic read_one(input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd1_valid", rd_valid, 1);
    check("rd1_data", rd_data, exp);
  endtask

  task automatic read_none(input logic [7:0] held);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("noread_valid", rd_valid, 0);
    check("noread_data", rd_data, held);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    ena        = 1'b0;
    probe      = 8'h00;
    trig_mask  = 8'h00;
    trig_value = 8'h00;
    arm        = 1'b0;
    rd_en      = 1'b0;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    read_none(8'h00);

    // Wrapped capture: 9 samples written, oldest (0x10) overwritten
    do_arm(8'hFF, 8'h15);
    run_to_done(8'h10, 4'd8);
    read_seq(8'h11, 8);
    check("wrap_end_state", state, 0);
    check("wrap_end_count", count, 0);

    // Immediate trigger, then a fifth read is ignored
    do_arm(8'hFF, 8'h10);
    run_to_done(8'h10, 4'd4);
    read_seq(8'h10, 4);
    check("imm_end_state", state, 0);
    read_none(8'h13);

    // ena gaps after the trigger
    do_arm(8'hFF, 8'h10);
    ena   = 1'b1;
    probe = 8'h10;
    tick();
    check("gap_trig_state", state, 2);
    check("gap_trig_count", count, 1);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe = 8'h11 + 8'(i);
      tick();
    end
    check("gap_hold_state", state, 2);
    check("gap_hold_count", count, 1);
    run_to_done(8'h14, 4'd4);
    read_one(8'h10);
    read_one(8'h14);
    read_one(8'h15);
    read_one(8'h16);
    check("gap_end_state", state, 0);

    // Re-arm mid-capture, plus arm colliding with rd_en in DONE
    do_arm(8'h00, 8'h00);
    ena   = 1'b1;
    probe = 8'h30;
    tick();
    check("rearm_post_state", state, 2);
    probe = 8'h31;
    do_arm(8'h00, 8'h00);
    run_to_done(8'h40, 4'd4);
    arm   = 1'b1;
    rd_en = 1'b1;
    tick();
    arm   = 1'b0;
    rd_en = 1'b0;
    check("armrd_state", state, 1);
    check("armrd_valid", rd_valid, 0);
    check("armrd_count", count, 0);
    run_to_done(8'h50, 4'd4);
    read_seq(8'h50, 4);
    check("rearm_end_state", state, 0);

    // Reset mid-readout (asynchronous, away from the clock edge)
    do_arm(8'hFF, 8'h15);
    run_to_done(8'h10, 4'd8);
    read_seq(8'h11, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    #1;
    rst_n = 1'b1;
    tick();
    read_none(8'h00);
    do_arm(8'hFF, 8'h22);
    run_to_done(8'h20, 4'd6);
    read_seq(8'h20, 6);
    check("post_rst_end_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
